// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch address path.
// Holds the default reset PC, fetch group size, sequencer states and kseg translation.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF    = 32'hBFC0_0000;
  localparam int unsigned FETCH_BYTES_DEF = 8;

  typedef enum logic {
    RUN   = 1'b0,
    DSLOT = 1'b1
  } fetch_state_e;

  // kseg0 and kseg1 are unmapped windows onto the low 512 MB of physical space.
  function automatic logic [31:0] kseg_xlate(input logic [31:0] vaddr);
    if (vaddr[31:29] == 3'b100 || vaddr[31:29] == 3'b101) begin
      return {3'b000, vaddr[28:0]};
    end
    return vaddr;
  endfunction

endpackage

// File: rtl/fetch_addr_xlate.sv
// Combinational virtual-to-physical translation for unmapped kernel segments.
// Kept as its own block so the data-side address path can reuse it.
module fetch_addr_xlate
  import fetch_pkg::*;
(
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  assign paddr = kseg_xlate(vaddr);

endmodule

// File: rtl/fetch_addr_sequencer.sv
// Fetch PC owner: picks the next ICache request address from flush, redirect,
// buffered delay-slot target, BPU target or sequential. Optional macro: FETCH_ADEL_CHECK_EN.
module fetch_addr_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int unsigned FETCH_BYTES = FETCH_BYTES_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        bpu_taken,
  input  logic        bpu_dely,
  input  logic [31:0] bpu_target,
  input  logic        icache_addr_ok,
  output logic        req_valid,
  output logic [31:0] fetch_vaddr,
  output logic [31:0] fetch_paddr,
`ifdef FETCH_ADEL_CHECK_EN
  output logic        fetch_adel,
`endif
  output logic        pend_valid
);

  localparam logic [31:0] GROUP_BYTES = 32'(FETCH_BYTES);
  localparam logic [31:0] GROUP_MASK  = ~(GROUP_BYTES - 32'd1);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pend_target;
  logic [31:0]  next_pc;
  logic [31:0]  seq_pc;
  logic         accept;

  assign accept = req_valid & icache_addr_ok;
  // Wraps to zero past the top group simply by 32-bit overflow.
  assign seq_pc = (pc & GROUP_MASK) + GROUP_BYTES;

  // NOTE: next_pc gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    next_pc = pc;
    if (flush) begin
      next_pc = flush_target;
    end else if (redirect) begin
      next_pc = redirect_target;
    end else if (accept) begin
      if (state == DSLOT) begin
        next_pc = pend_target;
      end else if (bpu_taken && !bpu_dely) begin
        next_pc = bpu_target;
      end else begin
        next_pc = seq_pc;
      end
    end
  end

  // Delay-slot tracker: the BPU is ignored while a target is already buffered.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RUN;
      pend_target <= '0;
    end else if (flush || redirect) begin
      state       <= RUN;
      pend_target <= '0;
    end else if (accept) begin
      if (state == DSLOT) begin
        state <= RUN;
      end else if (bpu_taken && bpu_dely) begin
        state       <= DSLOT;
        pend_target <= bpu_target;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc        <= RESET_PC;
`ifdef FETCH_ADEL_CHECK_EN
      req_valid  <= (RESET_PC[1:0] == 2'b00);
      fetch_adel <= 1'b0;
`else
      req_valid <= 1'b1;
`endif
    end else begin
      pc <= next_pc;
`ifdef FETCH_ADEL_CHECK_EN
      // A misaligned PC is never requested, so it holds until flush or redirect.
      req_valid  <= (next_pc[1:0] == 2'b00);
      fetch_adel <= (next_pc[1:0] != 2'b00);
`else
      req_valid <= 1'b1;
`endif
    end
  end

  assign fetch_vaddr = pc;
  assign pend_valid  = (state == DSLOT);

  fetch_addr_xlate u_xlate (
    .vaddr (pc),
    .paddr (fetch_paddr)
  );

endmodule

// File: tb/tb_fetch_addr_sequencer.sv
// Scoreboard bench for fetch_addr_sequencer: a queue-based fetch model predicts every
// post-edge output, a separate monitor compares. Honours FETCH_ADEL_CHECK_EN.
module tb_fetch_addr_sequencer;

`ifdef FETCH_ADEL_CHECK_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif
  localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;
  localparam int unsigned GROUP   = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush, redirect, bpu_taken, bpu_dely, icache_addr_ok;
  logic [31:0] flush_target, redirect_target, bpu_target;
  logic        req_valid, pend_valid;
  logic [31:0] fetch_vaddr, fetch_paddr;
  logic        adel_out;

  fetch_addr_sequencer dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .flush_target    (flush_target),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .bpu_taken       (bpu_taken),
    .bpu_dely        (bpu_dely),
    .bpu_target      (bpu_target),
    .icache_addr_ok  (icache_addr_ok),
    .req_valid       (req_valid),
    .fetch_vaddr     (fetch_vaddr),
    .fetch_paddr     (fetch_paddr),
`ifdef FETCH_ADEL_CHECK_EN
    .fetch_adel      (adel_out),
`endif
    .pend_valid      (pend_valid)
  );

`ifndef FETCH_ADEL_CHECK_EN
  assign adel_out = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vaddr;
    logic        pend;
    logic        rv;
    logic        adel;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model state: the PC and a list of at most one buffered target.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic        m_rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_xlate(input logic [31:0] v);
    if (v >= 32'h8000_0000 && v < 32'hC000_0000) return v - 32'h8000_0000 + (v >= 32'hA000_0000 ? -32'h2000_0000 : 32'h0);
    return v;
  endfunction

  function automatic logic aligned(input logic [31:0] v);
    return (v % 4) == 0;
  endfunction

  task automatic model_reset();
    m_pc = BOOT_PC;
    m_pend.delete();
    m_rv = 1'b1;
  endtask

  task automatic step(input logic fl, input logic [31:0] ft, input logic rd, input logic [31:0] rt,
                      input logic tk, input logic dl, input logic [31:0] tg, input logic ok);
    exp_t e;
    logic accept;
    @(negedge clk);
    flush = fl; flush_target = ft; redirect = rd; redirect_target = rt;
    bpu_taken = tk; bpu_dely = dl; bpu_target = tg; icache_addr_ok = ok;
    accept = m_rv && ok;
    if (fl) begin
      m_pc = ft; m_pend.delete();
    end else if (rd) begin
      m_pc = rt; m_pend.delete();
    end else if (accept) begin
      if (m_pend.size() != 0) begin
        m_pc = m_pend.pop_front();
      end else if (tk && !dl) begin
        m_pc = tg;
      end else begin
        if (tk) m_pend.push_back(tg);
        m_pc = m_pc - (m_pc % GROUP) + GROUP;
      end
    end
    m_rv = ADEL ? aligned(m_pc) : 1'b1;
    e.vaddr = m_pc;
    e.pend  = (m_pend.size() != 0);
    e.rv    = m_rv;
    e.adel  = ADEL && !aligned(m_pc);
    exp_q.push_back(e);
  endtask

  task automatic go(input logic ok);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, ok);
  endtask

  task automatic jump(input logic [31:0] a);
    step(1'b0, 32'h0, 1'b1, a, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    a = $urandom;
    r = $urandom_range(0, 99);
    if (r < 85) a[2:0] = 3'b000;
    else if (r < 95) a[1:0] = 2'b00;
    return a;
  endfunction

  // Monitor: compares whatever the model predicted for this edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("vaddr", fetch_vaddr, e.vaddr);
      check("paddr", fetch_paddr, model_xlate(e.vaddr));
      check("pend_valid", 32'(pend_valid), 32'(e.pend));
      check("req_valid", 32'(req_valid), 32'(e.rv));
      if (ADEL) check("fetch_adel", 32'(adel_out), 32'(e.adel));
    end
  end

  task automatic reset_now();
    @(negedge clk);
    resetn = 1'b0;
    icache_addr_ok = 1'b0; flush = 1'b0; redirect = 1'b0; bpu_taken = 1'b0;
    #1;
    check("rst_vaddr", fetch_vaddr, BOOT_PC);
    check("rst_paddr", fetch_paddr, 32'h1FC0_0000);
    check("rst_pend", 32'(pend_valid), 32'h0);
    if (ADEL) check("rst_adel", 32'(adel_out), 32'h0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    flush = 1'b0; redirect = 1'b0; bpu_taken = 1'b0; bpu_dely = 1'b0; icache_addr_ok = 1'b0;
    flush_target = '0; redirect_target = '0; bpu_target = '0;
    #2;
    reset_now();

    // Sequential fetch from boot vector.
    repeat (3) go(1'b1);
    // Taken, no delay-slot pending.
    jump(32'h8000_1000);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 32'h8000_2000, 1'b1);
    // Taken with delay slot as last word.
    jump(32'h8000_1000);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 32'h8000_3000, 1'b1);
    go(1'b1);
    // Stall in DSLOT with BPU noise that must be ignored.
    jump(32'h8000_1000);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 32'h8000_3000, 1'b1);
    repeat (3) step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 32'h8000_7000, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 32'h8000_7000, 1'b1);
    // Flush and redirect together in DSLOT.
    jump(32'h8000_1000);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 32'h8000_3000, 1'b1);
    step(1'b1, 32'hBFC0_0380, 1'b1, 32'h8000_4000, 1'b0, 1'b0, 0, 1'b1);
    go(1'b1);
    // Sequential wrap at top of address space.
    jump(32'hFFFF_FFF8);
    go(1'b1);
    // Reset in the middle of DSLOT.
    jump(32'h8000_1000);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 32'h8000_3000, 1'b1);
    reset_now();
    go(1'b1);
    // Misaligned redirect target.
    jump(32'h8000_0002);
    repeat (2) go(1'b1);
    jump(32'h8000_0010);
    go(1'b1);

    for (int i = 0; i < 2000; i++) begin
      logic tk;
      tk = ($urandom_range(0, 99) < 30);
      step($urandom_range(0, 99) < 3, rand_addr(),
           $urandom_range(0, 99) < 6, rand_addr(),
           tk, tk && ($urandom_range(0, 99) < 40), rand_addr(),
           $urandom_range(0, 99) < 70);
      if (i == 1000) reset_now();
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
